// File: rtl/id_hazard_regfile_if.sv
// Decode-stage bus between the ID stage and the register file / hazard unit.
// master: the pipeline side that drives addresses, hazard inputs and write-back.
// slave:  id_hazard_regfile.
interface id_hazard_regfile_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rt;
   logic              exe_mem_read;
   logic [REG_AW-1:0] exe_rt;
   logic              exe_bra_taken;
   logic              wb_regwrite;
   logic [REG_AW-1:0] wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic [DATA_W-1:0] id_reg1_val;
   logic [DATA_W-1:0] id_reg2_val;
   logic              stall;
   logic              if_id_flush;
   logic              id_exe_flush;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output id_rs, id_rt, id_uses_rt, exe_mem_read, exe_rt, exe_bra_taken,
             wb_regwrite, wb_rd, wb_data,
      input  id_reg1_val, id_reg2_val, stall, if_id_flush, id_exe_flush,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, exe_mem_read, exe_rt, exe_bra_taken,
             wb_regwrite, wb_rd, wb_data,
      output id_reg1_val, id_reg2_val, stall, if_id_flush, id_exe_flush,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/id_hazard_regfile.sv
// Decode-stage register file with load-use / taken-branch hazard control and
// saturating stall/flush event counters.
// Optional feature: define WB_BYPASS_EN to forward same-cycle write-back data
// to the read ports; otherwise reads see array contents only.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | normal issue
// STL   | load-use bubble now sits in EXE
// BRA   | wrong-path slot after a taken branch
module id_hazard_regfile #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clock,
   input  logic              reset,
   id_hazard_regfile_if.slave bus
);
   localparam int NREG = 1 << REG_AW;

   typedef enum logic [1:0] {ST_RUN, ST_STL, ST_BRA} state_t;

   state_t            state_q;
   state_t            state_n;
   logic [DATA_W-1:0] rf [NREG];
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              load_use;
   logic              stall_c;
   logic              if_id_flush_c;
   logic              id_exe_flush_c;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic [CNT_W-1:0]  flush_cnt_q;

   // register array: cleared on reset, written at the clock edge from write-back
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (bus.wb_regwrite) begin
         rf[bus.wb_rd] <= bus.wb_data;
      end
   end

   // asynchronous read ports, optionally forwarding the write-back in flight
   always_comb begin
      rd1 = rf[bus.id_rs];
      rd2 = rf[bus.id_rt];
`ifdef WB_BYPASS_EN
      if (bus.wb_regwrite && (bus.wb_rd == bus.id_rs)) rd1 = bus.wb_data;
      if (bus.wb_regwrite && (bus.wb_rd == bus.id_rt)) rd2 = bus.wb_data;
`endif
   end

   assign load_use = bus.exe_mem_read &
                     ((bus.exe_rt == bus.id_rs) |
                      (bus.id_uses_rt & (bus.exe_rt == bus.id_rt)));

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= ST_RUN;
      else        state_q <= state_n;
   end

   // next state and hazard outputs; a taken branch kills the stalled instruction
   // instead of holding it, so it overrides the stall
   always_comb begin
      state_n        = ST_RUN;
      stall_c        = 1'b0;
      if_id_flush_c  = 1'b0;
      id_exe_flush_c = 1'b0;
      case (state_q)
         ST_RUN, ST_STL, ST_BRA: begin
            stall_c        = load_use & ~bus.exe_bra_taken;
            id_exe_flush_c = load_use | bus.exe_bra_taken;
            if_id_flush_c  = bus.exe_bra_taken;
            if (bus.exe_bra_taken) state_n = ST_BRA;
            else if (load_use)     state_n = ST_STL;
            else                   state_n = ST_RUN;
         end
         default: state_n = ST_RUN;
      endcase
   end

   // saturating event counters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_c && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (bus.exe_bra_taken && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   // combinational outputs are forced low while reset is held
   assign bus.id_reg1_val  = reset ? rd1 : '0;
   assign bus.id_reg2_val  = reset ? rd2 : '0;
   assign bus.stall        = reset & stall_c;
   assign bus.if_id_flush  = reset & if_id_flush_c;
   assign bus.id_exe_flush = reset & id_exe_flush_c;
   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.flush_cnt    = flush_cnt_q;
endmodule

// File: tb/tb_id_hazard_regfile.sv
// Self-checking bench for id_hazard_regfile, built with 4-bit event counters
// so that counter saturation is reachable in a short run.
module tb_id_hazard_regfile;
   localparam int DATA_W = 16;
   localparam int REG_AW = 3;
   localparam int CNT_W  = 4;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   id_hazard_regfile_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) hz_if ();

   id_hazard_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (hz_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic        uses_rt;
      logic        mem_read;
      logic [2:0]  exe_rt;
      logic        bra;
      logic        we;
      logic [2:0]  wd;
      logic [15:0] wdata;
      logic        stall;
      logic        ifid;
      logic        idexe;
   } vec_t;

   typedef struct {
      logic [15:0] r1;
      logic [15:0] r2;
      logic        stall;
      logic        ifid;
      logic        idexe;
      logic [3:0]  scnt;
      logic [3:0]  fcnt;
   } exp_t;

   vec_t        vecs[12];
   exp_t        sb[$];
   logic [15:0] rf_m[8];
   logic [3:0]  scnt_m;
   logic [3:0]  fcnt_m;

   function automatic vec_t mk(input logic [2:0] rs, input logic [2:0] rt,
                               input logic uses_rt, input logic mem_read,
                               input logic [2:0] exe_rt, input logic bra,
                               input logic we, input logic [2:0] wd,
                               input logic [15:0] wdata, input logic stall,
                               input logic ifid, input logic idexe);
      vec_t v;
      v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.mem_read = mem_read;
      v.exe_rt = exe_rt; v.bra = bra; v.we = we; v.wd = wd; v.wdata = wdata;
      v.stall = stall; v.ifid = ifid; v.idexe = idexe;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      hz_if.id_rs         = v.rs;
      hz_if.id_rt         = v.rt;
      hz_if.id_uses_rt    = v.uses_rt;
      hz_if.exe_mem_read  = v.mem_read;
      hz_if.exe_rt        = v.exe_rt;
      hz_if.exe_bra_taken = v.bra;
      hz_if.wb_regwrite   = v.we;
      hz_if.wb_rd         = v.wd;
      hz_if.wb_data       = v.wdata;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) rf_m[i] = '0;
      scnt_m = '0;
      fcnt_m = '0;
   endtask

   // one cycle: drive after the rising edge, predict, compare at the falling edge
   task automatic apply(input vec_t v, input string tag);
      exp_t e;
      exp_t g;
      @(posedge clock);
      #1;
      drive(v);
      e.r1 = rf_m[v.rs];
      e.r2 = rf_m[v.rt];
`ifdef WB_BYPASS_EN
      if (v.we && v.wd == v.rs) e.r1 = v.wdata;
      if (v.we && v.wd == v.rt) e.r2 = v.wdata;
`endif
      e.stall = v.stall;
      e.ifid  = v.ifid;
      e.idexe = v.idexe;
      e.scnt  = scnt_m;
      e.fcnt  = fcnt_m;
      sb.push_back(e);
      if (v.we) rf_m[v.wd] = v.wdata;
      if (v.stall && scnt_m != 4'hF) scnt_m = scnt_m + 4'd1;
      if (v.bra && fcnt_m != 4'hF) fcnt_m = fcnt_m + 4'd1;
      @(negedge clock);
      g = sb.pop_front();
      chk({tag, ".reg1"},  hz_if.id_reg1_val,  g.r1);
      chk({tag, ".reg2"},  hz_if.id_reg2_val,  g.r2);
      chk({tag, ".stall"}, hz_if.stall,        g.stall);
      chk({tag, ".ifid"},  hz_if.if_id_flush,  g.ifid);
      chk({tag, ".idexe"}, hz_if.id_exe_flush, g.idexe);
      chk({tag, ".scnt"},  hz_if.stall_cnt,    g.scnt);
      chk({tag, ".fcnt"},  hz_if.flush_cnt,    g.fcnt);
   endtask

   initial begin
      vec_t idle;
      vec_t lu;
      checks   = 0;
      failures = 0;
      model_clear();

      //          rs rt urt mrd ert bra we wd wdata     stl ifid idexe
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 16'hBEEF, 0, 0, 0);
      vecs[1]  = mk(3, 1, 1, 0, 0, 0, 1, 5, 16'h1111, 0, 0, 0);
      vecs[2]  = mk(3, 5, 1, 0, 0, 0, 1, 5, 16'h1234, 0, 0, 0);
      vecs[3]  = mk(0, 5, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
      vecs[4]  = mk(2, 0, 0, 1, 2, 0, 0, 0, 16'h0000, 1, 0, 1);
      vecs[5]  = mk(2, 0, 0, 0, 2, 0, 0, 0, 16'h0000, 0, 0, 0);
      vecs[6]  = mk(0, 4, 0, 1, 4, 0, 0, 0, 16'h0000, 0, 0, 0);
      vecs[7]  = mk(0, 4, 1, 1, 4, 0, 0, 0, 16'h0000, 1, 0, 1);
      vecs[8]  = mk(1, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 1, 0, 1);
      vecs[9]  = mk(2, 0, 0, 1, 2, 1, 0, 0, 16'h0000, 0, 1, 1);
      vecs[10] = mk(6, 7, 1, 0, 0, 1, 0, 0, 16'h0000, 0, 1, 1);
      vecs[11] = mk(3, 5, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 0);
      idle = mk(0, 0, 0, 0, 7, 0, 0, 0, 16'h0000, 0, 0, 0);
      lu   = mk(2, 0, 0, 1, 2, 0, 0, 0, 16'h0000, 1, 0, 1);

      // reset held with hazard and write inputs active: outputs must stay low
      reset = 1'b0;
      drive(mk(0, 0, 1, 1, 0, 1, 1, 0, 16'hFFFF, 0, 0, 0));
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst.stall", hz_if.stall,        1'b0);
      chk("rst.ifid",  hz_if.if_id_flush,  1'b0);
      chk("rst.idexe", hz_if.id_exe_flush, 1'b0);
      chk("rst.reg1",  hz_if.id_reg1_val,  16'h0000);
      chk("rst.scnt",  hz_if.stall_cnt,    4'h0);
      chk("rst.fcnt",  hz_if.flush_cnt,    4'h0);
      drive(idle);
      #1 reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         hz_if.id_rs = 3'(i);
         hz_if.id_rt = 3'(i);
         #1;
         chk($sformatf("rst.rf%0d.r1", i), hz_if.id_reg1_val, 16'h0000);
         chk($sformatf("rst.rf%0d.r2", i), hz_if.id_reg2_val, 16'h0000);
      end

      for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("vec%0d", i));

      // counter saturation: 2**CNT_W+3 consecutive stall cycles
      for (int i = 0; i < (1 << CNT_W) + 3; i++) apply(lu, $sformatf("sat%0d", i));
      apply(idle, "sat_done");
      chk("sat.stall_cnt", hz_if.stall_cnt, 4'hF);

      // reset asserted mid-stall: outputs drop at once, state and counters clear
      apply(mk(3, 0, 0, 1, 3, 0, 0, 0, 16'h0000, 1, 0, 1), "pre_rst");
      #2 reset = 1'b0;
      #1;
      chk("midrst.stall", hz_if.stall,        1'b0);
      chk("midrst.idexe", hz_if.id_exe_flush, 1'b0);
      chk("midrst.reg1",  hz_if.id_reg1_val,  16'h0000);
      chk("midrst.scnt",  hz_if.stall_cnt,    4'h0);
      chk("midrst.fcnt",  hz_if.flush_cnt,    4'h0);
      model_clear();
      @(posedge clock);
      #3 reset = 1'b1;
      drive(idle);
      apply(lu, "post_rst_lu");
      apply(idle, "post_rst_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
